// File: rtl/uart_kbd_in.sv
// uart_kbd_in: serial keyboard front end for an MC6820 PIA port A.
// Receives 8N1 bytes on i_rx, maps them to the monitor's upper-case 7-bit
// ASCII set, and holds one key on o_pa_out with a strobe on o_ca1.
// Ports:
//   i_clk        system clock, rising edge
//   i_reset      synchronous active-high reset
//   i_rx         asynchronous serial input, idle high
//   i_ack        key consumed (level, sampled every clock)
//   o_pa_out     to PIA PAI: [7] key pending, [6:0] ASCII
//   o_ca1        to PIA CA1: high STROBE_CYCLES clocks per accepted key
//   o_frame_err  one-clock pulse on a bad stop bit
//   o_overrun    sticky key-dropped flag, cleared by i_ack or reset
module uart_kbd_in #(
  parameter int unsigned CLKS_PER_BIT  = 104,
  parameter int unsigned STROBE_CYCLES = 8
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_rx,
  input  logic       i_ack,
  output logic [7:0] o_pa_out,
  output logic       o_ca1,
  output logic       o_frame_err,
  output logic       o_overrun
);

  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned STB_W  = $clog2(STROBE_CYCLES + 1);
  localparam logic [BAUD_W-1:0] HALF_LAST  = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BAUD_W-1:0] BIT_LAST   = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [STB_W-1:0]  STB_RELOAD = STB_W'(STROBE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  logic              r_rx_meta;
  logic              r_rx_s;
  state_t            r_state;
  logic [BAUD_W-1:0] r_baud_cnt;
  logic [2:0]        r_bit_cnt;
  logic [7:0]        r_shift;
  logic [7:0]        r_pa_out;
  logic              r_ca1;
  logic [STB_W-1:0]  r_stb_cnt;
  logic              r_frame_err;
  logic              r_overrun;

  state_t            w_state_nxt;
  logic [BAUD_W-1:0] w_baud_nxt;
  logic [2:0]        w_bit_nxt;
  logic [7:0]        w_shift_nxt;
  logic              w_byte_done;
  logic              w_frame_err;
  logic              w_load;
  logic [6:0]        w_ascii;

  // Keyboard byte to monitor ASCII (lower case folded, LF->CR, DEL->'_').
  function automatic logic [6:0] f_translate(input logic [7:0] b);
    if (b >= 8'h61 && b <= 8'h7A) return 7'(b - 8'h20);
    else if (b == 8'h0A)          return 7'h0D;
    else if (b == 8'h7F)          return 7'h5F;
    else                          return 7'(b);
  endfunction

  // Two-flop synchronizer; resets to the idle level so reset cannot fake a start.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= i_rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  // Receiver state and counters.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_baud_cnt <= w_baud_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_shift    <= w_shift_nxt;
    end
  end

  // Receiver next state; all sampling is relative to the mid-start point.
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud_cnt;
    w_bit_nxt   = r_bit_cnt;
    w_shift_nxt = r_shift;
    w_byte_done = 1'b0;
    w_frame_err = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_rx_s) begin
          w_state_nxt = S_START;
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
        end
      end
      S_START: begin
        if (r_baud_cnt == HALF_LAST) begin
          w_baud_nxt  = '0;
          w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
        end else begin
          w_baud_nxt = r_baud_cnt + BAUD_W'(1);
        end
      end
      S_DATA: begin
        if (r_baud_cnt == BIT_LAST) begin
          w_baud_nxt  = '0;
          w_shift_nxt = {r_rx_s, r_shift[7:1]};
          if (r_bit_cnt == 3'd7) w_state_nxt = S_STOP;
          else                   w_bit_nxt   = r_bit_cnt + 3'(1);
        end else begin
          w_baud_nxt = r_baud_cnt + BAUD_W'(1);
        end
      end
      S_STOP: begin
        if (r_baud_cnt == BIT_LAST) begin
          w_baud_nxt = '0;
          if (r_rx_s) begin
            w_byte_done = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_frame_err = 1'b1;
            w_state_nxt = S_WAIT_HIGH;
          end
        end else begin
          w_baud_nxt = r_baud_cnt + BAUD_W'(1);
        end
      end
      // Wait out a break so it reports a single framing error.
      S_WAIT_HIGH: begin
        if (r_rx_s) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bytes with bit 7 set are dropped silently.
  assign w_ascii = f_translate(r_shift);
  assign w_load  = w_byte_done && !r_shift[7];

  // Key holding register, strobe and error flags.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pa_out    <= '0;
      r_ca1       <= 1'b0;
      r_stb_cnt   <= '0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_frame_err;
      if (w_load && (!r_pa_out[7] || i_ack)) begin
        r_pa_out  <= {1'b1, w_ascii};
        r_ca1     <= 1'b1;
        r_stb_cnt <= STB_RELOAD;
        if (i_ack) r_overrun <= 1'b0;
      end else begin
        if (w_load) begin
          r_overrun <= 1'b1;
        end else if (i_ack) begin
          r_pa_out[7] <= 1'b0;
          r_overrun   <= 1'b0;
        end
        if (r_stb_cnt != '0) r_stb_cnt <= r_stb_cnt - STB_W'(1);
        else                 r_ca1     <= 1'b0;
      end
    end
  end

  assign o_pa_out    = r_pa_out;
  assign o_ca1       = r_ca1;
  assign o_frame_err = r_frame_err;
  assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_uart_kbd_in.sv
// tb_uart_kbd_in: directed self-checking bench for uart_kbd_in with
// CLKS_PER_BIT=16 and STROBE_CYCLES=4. Inputs change on the falling edge,
// outputs are observed on the falling edge.
module tb_uart_kbd_in;

  localparam int unsigned CPB = 16;
  localparam int unsigned STB = 4;
  // Falling rx edge to first strobe cycle: 2 sync + 1 state + half bit + 9 bits.
  localparam int LOAD_LAT = 3 + 8 + 9 * 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       ack = 1'b0;
  logic [7:0] pa_out;
  logic       ca1;
  logic       frame_err;
  logic       overrun;

  int checks = 0;
  int failures = 0;
  int frame_cyc = 0;

  // Output monitor state.
  int         cyc = 0;
  logic       ca1_q = 1'b0;
  logic       rose_q = 1'b0;
  int         strobe_cnt = 0;
  int         rise_cyc = 0;
  logic [7:0] rise_pa = 8'h00;
  logic [7:0] rise_next_pa = 8'h00;
  int         run = 0;
  int         last_width = 0;
  int         fe_cnt = 0;
  int         fe_cyc = 0;

  uart_kbd_in #(
    .CLKS_PER_BIT (CPB),
    .STROBE_CYCLES(STB)
  ) dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_rx       (rx),
    .i_ack      (ack),
    .o_pa_out   (pa_out),
    .o_ca1      (ca1),
    .o_frame_err(frame_err),
    .o_overrun  (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    ca1_q  <= ca1;
    rose_q <= ca1 && !ca1_q;
    if (ca1 && !ca1_q) begin
      strobe_cnt <= strobe_cnt + 1;
      rise_cyc   <= cyc;
      rise_pa    <= pa_out;
      run        <= 1;
    end else if (ca1) begin
      run <= run + 1;
    end
    if (!ca1 && ca1_q) last_width <= run;
    if (rose_q) rise_next_pa <= pa_out;
    if (frame_err) begin
      fe_cnt <= fe_cnt + 1;
      fe_cyc <= cyc;
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int low_bits);
    frame_cyc = cyc;
    rx = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_clks(CPB);
    end
    rx = stop;
    wait_clks(CPB);
    if (low_bits > 0) begin
      rx = 1'b0;
      wait_clks(low_bits * CPB);
    end
    rx = 1'b1;
    wait_clks(2 * CPB);
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    wait_clks(1);
    ack = 1'b0;
    wait_clks(1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wait_clks(3);
    checks++; if (pa_out !== 8'h00) begin failures++; $display("FAIL reset_pa got=%h exp=00", pa_out); end
    checks++; if (ca1 !== 1'b0) begin failures++; $display("FAIL reset_ca1 got=%b exp=0", ca1); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_fe got=%b exp=0", frame_err); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_ovr got=%b exp=0", overrun); end
    reset = 1'b0;
    wait_clks(4);
  endtask

  task automatic test_basic();
    int s0, f0;
    s0 = strobe_cnt; f0 = fe_cnt;
    send_frame(8'h61, 1'b1, 0);
    checks++; if (strobe_cnt - s0 !== 1) begin failures++; $display("FAIL basic_strobes got=%0d exp=1", strobe_cnt - s0); end
    checks++; if (rise_pa !== 8'hC1) begin failures++; $display("FAIL basic_pa_at_strobe got=%h exp=c1", rise_pa); end
    checks++; if (rise_cyc - frame_cyc !== LOAD_LAT) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", rise_cyc - frame_cyc, LOAD_LAT); end
    checks++; if (last_width !== STB) begin failures++; $display("FAIL basic_ca1_width got=%0d exp=%0d", last_width, STB); end
    checks++; if (fe_cnt - f0 !== 0) begin failures++; $display("FAIL basic_fe got=%0d exp=0", fe_cnt - f0); end
    checks++; if (pa_out !== 8'hC1) begin failures++; $display("FAIL basic_pa_hold got=%h exp=c1", pa_out); end
    pulse_ack();
    checks++; if (pa_out !== 8'h41) begin failures++; $display("FAIL basic_ack got=%h exp=41", pa_out); end
  endtask

  task automatic test_translate();
    send_frame(8'h0A, 1'b1, 0);
    checks++; if (pa_out !== 8'h8D) begin failures++; $display("FAIL xlat_lf got=%h exp=8d", pa_out); end
    pulse_ack();
    checks++; if (pa_out !== 8'h0D) begin failures++; $display("FAIL xlat_lf_ack got=%h exp=0d", pa_out); end
    send_frame(8'h7F, 1'b1, 0);
    checks++; if (pa_out !== 8'hDF) begin failures++; $display("FAIL xlat_del got=%h exp=df", pa_out); end
    pulse_ack();
    checks++; if (pa_out !== 8'h5F) begin failures++; $display("FAIL xlat_del_ack got=%h exp=5f", pa_out); end
  endtask

  task automatic test_back_to_back();
    int s0;
    s0 = strobe_cnt;
    send_frame(8'h41, 1'b1, 0);
    send_frame(8'h42, 1'b1, 0);
    checks++; if (pa_out !== 8'hC1) begin failures++; $display("FAIL ovr_pa got=%h exp=c1", pa_out); end
    checks++; if (strobe_cnt - s0 !== 1) begin failures++; $display("FAIL ovr_strobes got=%0d exp=1", strobe_cnt - s0); end
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_flag got=%b exp=1", overrun); end
    pulse_ack();
    checks++; if (pa_out !== 8'h41) begin failures++; $display("FAIL ovr_ack_pa got=%h exp=41", pa_out); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_ack_flag got=%b exp=0", overrun); end
  endtask

  task automatic test_frame_err();
    int s0, f0, fc;
    s0 = strobe_cnt; f0 = fe_cnt;
    send_frame(8'h55, 1'b0, 40);
    fc = frame_cyc;
    checks++; if (fe_cnt - f0 !== 1) begin failures++; $display("FAIL fe_count got=%0d exp=1", fe_cnt - f0); end
    checks++; if (fe_cyc - fc !== LOAD_LAT) begin failures++; $display("FAIL fe_timing got=%0d exp=%0d", fe_cyc - fc, LOAD_LAT); end
    checks++; if (strobe_cnt - s0 !== 0) begin failures++; $display("FAIL fe_no_strobe got=%0d exp=0", strobe_cnt - s0); end
    checks++; if (pa_out !== 8'h41) begin failures++; $display("FAIL fe_pa_kept got=%h exp=41", pa_out); end
    send_frame(8'h31, 1'b1, 0);
    checks++; if (pa_out !== 8'hB1) begin failures++; $display("FAIL fe_next_pa got=%h exp=b1", pa_out); end
    checks++; if (fe_cnt - f0 !== 1) begin failures++; $display("FAIL fe_total got=%0d exp=1", fe_cnt - f0); end
  endtask

  task automatic test_glitch_high_bit();
    int s0, f0;
    s0 = strobe_cnt; f0 = fe_cnt;
    rx = 1'b0;
    wait_clks(3);
    rx = 1'b1;
    wait_clks(4 * CPB);
    checks++; if (strobe_cnt - s0 !== 0) begin failures++; $display("FAIL glitch_strobe got=%0d exp=0", strobe_cnt - s0); end
    checks++; if (fe_cnt - f0 !== 0) begin failures++; $display("FAIL glitch_fe got=%0d exp=0", fe_cnt - f0); end
    send_frame(8'hE1, 1'b1, 0);
    checks++; if (pa_out !== 8'hB1) begin failures++; $display("FAIL hibit_pa got=%h exp=b1", pa_out); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL hibit_ovr got=%b exp=0", overrun); end
    checks++; if (strobe_cnt - s0 !== 0) begin failures++; $display("FAIL hibit_strobe got=%0d exp=0", strobe_cnt - s0); end
    pulse_ack();
  endtask

  task automatic test_ack_hold();
    ack = 1'b1;
    send_frame(8'h62, 1'b1, 0);
    ack = 1'b0;
    wait_clks(1);
    checks++; if (rise_pa !== 8'hC2) begin failures++; $display("FAIL ackhold_load got=%h exp=c2", rise_pa); end
    checks++; if (rise_next_pa !== 8'h42) begin failures++; $display("FAIL ackhold_next got=%h exp=42", rise_next_pa); end
    checks++; if (pa_out !== 8'h42) begin failures++; $display("FAIL ackhold_pa got=%h exp=42", pa_out); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d;
    int s0, f0;
    d = 8'h33;
    rx = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      wait_clks(CPB);
    end
    rx = d[4];
    wait_clks(CPB / 2);
    reset = 1'b1;
    wait_clks(2);
    checks++; if (pa_out !== 8'h00) begin failures++; $display("FAIL rstmid_pa got=%h exp=00", pa_out); end
    checks++; if (ca1 !== 1'b0) begin failures++; $display("FAIL rstmid_ca1 got=%b exp=0", ca1); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL rstmid_ovr got=%b exp=0", overrun); end
    reset = 1'b0;
    rx = 1'b1;
    s0 = strobe_cnt; f0 = fe_cnt;
    wait_clks(12 * CPB);
    checks++; if (strobe_cnt - s0 !== 0) begin failures++; $display("FAIL rstmid_quiet got=%0d exp=0", strobe_cnt - s0); end
    send_frame(8'h34, 1'b1, 0);
    checks++; if (pa_out !== 8'hB4) begin failures++; $display("FAIL rstmid_next_pa got=%h exp=b4", pa_out); end
    checks++; if (strobe_cnt - s0 !== 1) begin failures++; $display("FAIL rstmid_strobes got=%0d exp=1", strobe_cnt - s0); end
    checks++; if (fe_cnt - f0 !== 0) begin failures++; $display("FAIL rstmid_fe got=%0d exp=0", fe_cnt - f0); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_translate();
    test_back_to_back();
    test_frame_err();
    test_glitch_high_bit();
    test_ack_hold();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
